// File: rtl/operand_prep_pipe_if.sv
// Decode-side bundle for operand_prep_pipe: instruction handshake, writeback port and registered operand outputs.
interface operand_prep_pipe_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] reg1;
    logic [ADDR_W-1:0] reg2;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] pc_offset;
    logic              clearing;

    modport master (
        output in_valid, instr, reg1, reg2, alu_src, mem_read, mem_write,
               wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, read_data1, read_data2, pc_offset, clearing
    );

    modport slave (
        input  in_valid, instr, reg1, reg2, alu_src, mem_read, mem_write,
               wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, read_data1, read_data2, pc_offset, clearing
    );
endinterface

// File: rtl/operand_prep_pipe.sv
// LEGv8 operand prep: register file, immediate/offset decode, operand-2 select into a one-entry output register.
// Latency 1 cycle accept->out_valid; stalls (outputs held, in_ready low) while out_valid && !out_ready.
module operand_prep_pipe #(
    parameter int DATA_W      = 64,
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter bit ZERO_REG_EN = 1'b1,
    parameter bit BYPASS_EN   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    operand_prep_pipe_if.slave    bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_ok;

    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] dt_imm;
    logic [DATA_W-1:0] alu_imm;
    logic [DATA_W-1:0] pco;

    logic              clearing;
    logic              in_ready;
    logic              accept;
    logic              out_valid;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] pco_q;

    // Addresses past the file and the XZR slot neither hold nor accept data.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM_REGS_W) && !(ZERO_REG_EN && (a == LAST_IDX));
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_idx <= clr_idx + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == LAST_IDX) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    assign clearing = (state == CLEAR);
    assign in_ready = (state == RUN) && (!out_valid || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign wb_ok    = (state == RUN) && bus.wb_en && addr_live(bus.wb_addr);
    assign rf_we    = !reset && (clearing || wb_ok);
    assign rf_waddr = clearing ? clr_idx : bus.wb_addr;
    assign rf_wdata = clearing ? '0 : bus.wb_data;

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rf_we && (rf_waddr == ADDR_W'(i)))
                regs[i] <= rf_wdata;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.reg1 == ADDR_W'(i)) rd1 = regs[i];
            if (bus.reg2 == ADDR_W'(i)) rd2 = regs[i];
        end
        if (BYPASS_EN && wb_ok && (bus.wb_addr == bus.reg1)) rd1 = bus.wb_data;
        if (BYPASS_EN && wb_ok && (bus.wb_addr == bus.reg2)) rd2 = bus.wb_data;
        if (!addr_live(bus.reg1)) rd1 = '0;
        if (!addr_live(bus.reg2)) rd2 = '0;
    end

    assign dt_imm  = {{(DATA_W-9){bus.instr[20]}}, bus.instr[20:12]};
    assign alu_imm = {{(DATA_W-12){1'b0}}, bus.instr[21:10]};

    // D-type address offset wins over the ALU immediate when both could apply.
    always_comb begin
        op2 = rd2;
        if (bus.alu_src)
            op2 = (bus.mem_read || bus.mem_write) ? dt_imm : alu_imm;
    end

    always_comb begin
        pco = '0;
        if ((bus.instr[31:26] == 6'b000101) || (bus.instr[31:26] == 6'b100101))
            pco = {{(DATA_W-26){bus.instr[25]}}, bus.instr[25:0]};
        else if ((bus.instr[31:24] == 8'b01010100) || (bus.instr[31:25] == 7'b1011010))
            pco = {{(DATA_W-19){bus.instr[23]}}, bus.instr[23:5]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            pco_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rd1_q     <= rd1;
            rd2_q     <= op2;
            pco_q     <= pco;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.read_data1 = rd1_q;
    assign bus.read_data2 = rd2_q;
    assign bus.pc_offset  = pco_q;
    assign bus.clearing   = clearing;
endmodule

// File: tb/tb_operand_prep_pipe.sv
// Scoreboarded bench for operand_prep_pipe; a second instance without bypass mirrors the same stimulus.
module tb_operand_prep_pipe;
    typedef struct packed {
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] pco;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        src;
        logic        mr;
        logic        mw;
        exp_t        e;
    } vec_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] ADD_I = {11'b10001011000, 5'd7, 6'd0, 5'd3, 5'd4};

    logic clock = 1'b0;
    logic reset;
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    operand_prep_pipe_if #(.DATA_W(64), .ADDR_W(5)) bus ();
    operand_prep_pipe_if #(.DATA_W(64), .ADDR_W(5)) bus0 ();

    assign bus0.in_valid  = bus.in_valid;
    assign bus0.instr     = bus.instr;
    assign bus0.reg1      = bus.reg1;
    assign bus0.reg2      = bus.reg2;
    assign bus0.alu_src   = bus.alu_src;
    assign bus0.mem_read  = bus.mem_read;
    assign bus0.mem_write = bus.mem_write;
    assign bus0.wb_en     = bus.wb_en;
    assign bus0.wb_addr   = bus.wb_addr;
    assign bus0.wb_data   = bus.wb_data;
    assign bus0.out_ready = bus.out_ready;

    operand_prep_pipe dut (.clock(clock), .reset(reset), .bus(bus));
    operand_prep_pipe #(.BYPASS_EN(1'b0)) dut_nobyp (.clock(clock), .reset(reset), .bus(bus0));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
    endtask

    // Results are checked on the negedge before the edge that transfers them.
    task automatic monitor();
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clock);
            if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                vectors++;
                got = {bus.read_data1, bus.read_data2, bus.pc_offset};
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result got %h", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL result got rd1=%h rd2=%h pco=%h want rd1=%h rd2=%h pco=%h",
                                 got.rd1, got.rd2, got.pco, e.rd1, e.rd2, e.pco);
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [4:0] r1, input logic [4:0] r2,
                        input logic src, input logic mr, input logic mw, input exp_t e);
        int guard = 0;
        bus.in_valid  = 1'b1;
        bus.instr     = ins;
        bus.reg1      = r1;
        bus.reg2      = r2;
        bus.alu_src   = src;
        bus.mem_read  = mr;
        bus.mem_write = mw;
        sb.push_back(e);
        #1;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout in_ready=%b want 1", bus.in_ready);
        end
        step();
        bus.wb_en = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 20) begin
            step();
            g++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        int cnt = 0;
        bus.in_valid = 0; bus.instr = '0; bus.reg1 = '0; bus.reg2 = '0;
        bus.alu_src = 0; bus.mem_read = 0; bus.mem_write = 0;
        bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
        reset = 1'b1;
        step();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.clearing !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl out_valid=%b clearing=%b in_ready=%b want 0 1 0",
                     bus.out_valid, bus.clearing, bus.in_ready);
        end
        vectors++;
        if ({bus.read_data1, bus.read_data2, bus.pc_offset} !== '0) begin
            miscompares++;
            $display("FAIL reset_data rd1=%h rd2=%h pco=%h want 0", bus.read_data1, bus.read_data2, bus.pc_offset);
        end
        // Partial clear, then reset again: the count must restart from zero.
        reset = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        while (bus.clearing === 1'b1 && cnt < 100) begin
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_idle cycle=%0d in_ready=%b out_valid=%b want 0 0", cnt, bus.in_ready, bus.out_valid);
            end
            cnt++;
            if (cnt == 10) begin
                bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 64'hDEAD;
                bus.in_valid = 1'b1; bus.reg1 = 5'd5;
            end
            if (cnt == 11) idle();
            step();
        end
        vectors++;
        if (cnt !== 32) begin
            miscompares++;
            $display("FAIL clear_cycles got %0d want 32", cnt);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_clear in_ready=%b want 1", bus.in_ready);
        end
        send(32'h0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, '{64'h0, 64'h0, 64'h0});
        idle();
        drain();
    endtask

    task automatic test_regfile();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 64'h1234;
        step();
        bus.wb_en = 1'b0;
        send(32'h0, 5'd3, 5'd31, 1'b0, 1'b0, 1'b0, '{64'h1234, 64'h0, 64'h0});
        idle();
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL out_valid_drop out_valid=%b want 0", bus.out_valid);
        end
        bus.wb_en = 1'b1; bus.wb_addr = 5'd31; bus.wb_data = 64'hFF;
        step();
        bus.wb_en = 1'b0;
        send(32'h0, 5'd31, 5'd3, 1'b0, 1'b0, 1'b0, '{64'h0, 64'h1234, 64'h0});
        idle();
        drain();
    endtask

    task automatic test_bypass();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 64'hAA;
        send(32'h0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, '{64'hAA, 64'h0, 64'h0});
        vectors++;
        if (bus0.out_valid !== 1'b1 || bus0.read_data1 !== 64'h0) begin
            miscompares++;
            $display("FAIL no_bypass_old out_valid=%b rd1=%h want 1 0", bus0.out_valid, bus0.read_data1);
        end
        idle();
        drain();
        send(32'h0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, '{64'hAA, 64'hAA, 64'h0});
        vectors++;
        if (bus0.read_data1 !== 64'hAA) begin
            miscompares++;
            $display("FAIL no_bypass_written rd1=%h want aa", bus0.read_data1);
        end
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        vec_t tbl[9];
        time  t0;
        tbl[0] = '{{11'b11111000010, 9'h1F0, 2'b00, 5'd3, 5'd1}, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0,
                   '{64'h1234, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0}};
        tbl[1] = '{{11'b11111000000, 9'h0FF, 2'b00, 5'd3, 5'd1}, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1,
                   '{64'hAA, 64'hFF, 64'h0}};
        tbl[2] = '{{10'b1001000100, 12'hFFF, 5'd3, 5'd1}, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0,
                   '{64'h1234, 64'hFFF, 64'h0}};
        tbl[3] = '{{6'b000101, 26'h3FF_FFFF}, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0,
                   '{64'h0, 64'h1234, ONES}};
        tbl[4] = '{{6'b100101, 26'h000_0100}, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0,
                   '{64'hAA, 64'hAA, 64'h100}};
        tbl[5] = '{{8'hB4, 19'h00010, 5'd0}, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                   '{64'h0, 64'h0, 64'h10}};
        tbl[6] = '{{8'h54, 19'h7FFFF, 5'd1}, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0,
                   '{64'h0, 64'h0, ONES}};
        tbl[7] = '{ADD_I, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0,
                   '{64'h1234, 64'hAA, 64'h0}};
        tbl[8] = '{{8'hB5, 19'h40000, 5'd2}, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0,
                   '{64'h1234, 64'h1234, 64'hFFFF_FFFF_FFFC_0000}};
        t0 = $time;
        for (int i = 0; i < 9; i++)
            send(tbl[i].ins, tbl[i].r1, tbl[i].r2, tbl[i].src, tbl[i].mr, tbl[i].mw, tbl[i].e);
        vectors++;
        if ($time - t0 !== 90) begin
            miscompares++;
            $display("FAIL throughput took %0t want 90", $time - t0);
        end
        idle();
        drain();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        send(ADD_I, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, '{64'h1234, 64'hAA, 64'h0});
        bus.in_valid = 1'b1;
        bus.instr    = {8'hB4, 19'h00020, 5'd0};
        bus.reg1     = 5'd7;
        bus.reg2     = 5'd3;
        sb.push_back('{64'hAA, 64'h1234, 64'h20});
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.read_data1 !== 64'h1234 ||
                bus.read_data2 !== 64'hAA || bus.pc_offset !== 64'h0) begin
                miscompares++;
                $display("FAIL stall_hold cycle=%0d out_valid=%b in_ready=%b rd1=%h rd2=%h pco=%h want 1 0 1234 aa 0",
                         i, bus.out_valid, bus.in_ready, bus.read_data1, bus.read_data2, bus.pc_offset);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready in_ready=%b want 1", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_valid !== 1'b1 || sb.size() != 1) begin
            miscompares++;
            $display("FAIL release_handoff out_valid=%b pending=%0d want 1 1", bus.out_valid, sb.size());
        end
        idle();
        drain();
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL final_drop out_valid=%b want 0", bus.out_valid);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_regfile();
        test_bypass();
        test_back_to_back();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/operand_prep_pipe.md
Name: operand_prep_pipe

Overview:
Parametrised successor to the operand-preparation stage of the LEGv8 datapath. It holds the register file, decodes the immediate and PC-offset fields, and selects ALU operand 2. Results go out through a one-entry registered output stage with a valid/ready handshake, replacing the old free-running 6-phase counter. It sits between instruction fetch/decode and the ALU/memory stage. Writeback arrives from the final stage.

Parameters:
DATA_W, 64, width of registers, operands and pc_offset.
NUM_REGS, 32, number of architectural registers; must be ≤ 2**ADDR_W.
ADDR_W, 5, register address width.
ZERO_REG_EN, 1, 1 = register NUM_REGS-1 is XZR: reads 0, writes dropped.
BYPASS_EN, 1, 1 = same-cycle writeback is forwarded to reads.

Ports:
clock  in  1  main clock, all logic on posedge
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  block can accept an instruction this cycle
instr  in  32  full instruction word (immediate/offset source)
reg1  in  ADDR_W  operand-1 register address
reg2  in  ADDR_W  operand-2 register address
alu_src  in  1  0 = operand 2 from reg2, 1 = immediate
mem_read  in  1  D-type load flag
mem_write  in  1  D-type store flag
wb_en  in  1  writeback enable
wb_addr  in  ADDR_W  writeback register
wb_data  in  DATA_W  writeback data
out_valid  out  1  output stage holds a result
out_ready  in  1  downstream consumes the result
read_data1  out  DATA_W  operand 1
read_data2  out  DATA_W  operand 2 (register or immediate)
pc_offset  out  DATA_W  sign-extended branch offset
clearing  out  1  high while the register file is being zeroed

Behaviour:
- FSM states are CLEAR and RUN. A reset sample forces CLEAR with clr_idx=0 and takes priority over everything else.
- Reset values: out_valid=0, read_data1=read_data2=pc_offset=0, clearing=1, in_ready=0.
- CLEAR: writes 0 to register[clr_idx] each cycle and increments clr_idx. After register NUM_REGS-1 is written, the FSM moves to RUN on the next edge, so clearing lasts exactly NUM_REGS cycles.
- In CLEAR, wb_en and in_valid are ignored. Reset asserted mid-CLEAR restarts at clr_idx=0.
- RUN: clearing=0 and in_ready = !out_valid || out_ready (combinational).
- Accept occurs when in_valid && in_ready. Operands are computed from inputs at the accept edge and registered, so out_valid rises 1 cycle after accept.
- Stall: while out_valid && !out_ready, all outputs hold stable and no accept occurs.
- If out_ready is high and there is no new accept, out_valid drops the next cycle. Back-to-back accepts sustain 1 result per cycle.
- Writeback in RUN: when wb_en=1, register[wb_addr] ← wb_data at the edge, independent of the handshake.
- Writeback is dropped when wb_addr ≥ NUM_REGS, or when ZERO_REG_EN=1 and wb_addr = NUM_REGS-1.
- Register read: a register reads as 0 if its address ≥ NUM_REGS, or if ZERO_REG_EN=1 and the address = NUM_REGS-1.
- Same-cycle read/write: with BYPASS_EN=1 and an accepted read whose address matches a valid wb_addr, the read returns wb_data. With BYPASS_EN=0 it returns the old register value.
- read_data2 selection:
  - alu_src=0: register[reg2] (same bypass rules).
  - alu_src=1 and (mem_read || mem_write): sign-extend instr[20:12] (DT_address) to DATA_W.
  - alu_src=1 otherwise: zero-extend instr[21:10] (ALU_immediate). The D-type case takes priority.
- pc_offset (no shift applied; the branch unit shifts):
  - instr[31:26] ∈ {000101, 100101} (B/BL): sign-extend instr[25:0].
  - instr[31:24] = 01010100 (B.cond) or instr[31:25] = 1011010 (CBZ/CBNZ): sign-extend instr[23:5].
  - Otherwise: 0.

Test Plan:
1. Reset for 1 cycle, then idle → clearing=1 for exactly 32 cycles, in_ready=0 throughout, and in_ready=1 on cycle 33. wb_en pulsed to X5 during clearing → X5 still reads 0 afterwards.
2. Write X3=0x1234 (wb_en=1 for one cycle); next cycle accept reg1=3, alu_src=0, reg2=31 → one cycle later out_valid=1, read_data1=0x1234, read_data2=0. Then write X31=0xFF; a later read of X31 returns 0.
3. Same-cycle hazard: wb_en=1, wb_addr=7, wb_data=0xAA and accept reg1=7 → read_data1=0xAA with BYPASS_EN=1. Rebuilt with BYPASS_EN=0 → old value 0.
4. Immediate selection:
   - LDUR with instr[20:12]=9'h1F0, mem_read=1, alu_src=1 → read_data2=0xFFFF_FFFF_FFFF_FFF0.
   - ADDI with instr[21:10]=12'hFFF, alu_src=1 → read_data2=0xFFF.
5. Offsets:
   - B with imm26=0x3FFFFFF → pc_offset=all ones (−1).
   - CBZ with instr[23:5]=19'h00010 → pc_offset=0x10.
   - ADD → pc_offset=0.
6. Hold out_ready=0 for 4 cycles after an accept with in_valid=1 held → outputs stable, in_ready=0. Raise out_ready → the held result transfers, the next instruction is accepted the same edge, and out_valid stays 1.
